// File: rtl/glyph_row_streamer.sv
// rtl/glyph_row_streamer.sv - glyph ROM with registered read and one-pixel-per-cycle row streaming
// Optional feature macro: GLYPH_MIRROR_EN (latched mirror, LSB-first streaming).
module glyph_row_streamer #(
  parameter int    GLYPH_W    = 8,
  parameter int    GLYPH_H    = 8,
  parameter int    NUM_GLYPHS = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          req,
  input  logic [$clog2(NUM_GLYPHS)-1:0] glyph_code,
  input  logic [$clog2(GLYPH_H)-1:0]    row,
  input  logic                          mirror,
  output logic                          ready,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic                          pix,
  output logic                          pix_last,
  output logic                          busy
);

  localparam int CW    = $clog2(NUM_GLYPHS);
  localparam int RW    = $clog2(GLYPH_H);
  localparam int AW    = CW + RW;
  localparam int CNT_W = $clog2(GLYPH_W);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  logic [1:0]         state;
  logic [GLYPH_W-1:0] rom_word;
  logic [GLYPH_W-1:0] rom_q;
  logic [GLYPH_W-1:0] shift_reg;
  logic [CNT_W-1:0]   cnt;
  logic [AW-1:0]      addr;
  logic               mirror_q;
  logic               accept;
  logic               last;

  assign addr   = {glyph_code, row};
  assign accept = (state == IDLE) && req;
  assign last   = (cnt == CNT_W'(GLYPH_W - 1));

  generate
    if ((INIT_FILE == "") && (GLYPH_W == 8)) begin : g_builtin
      // Codes 1 and 2 are the left- and right-biased marker dots; all else blank.
      always_comb begin
        rom_word = '0;
        if (int'(glyph_code) == 1) begin
          if (int'(row) == 3 || int'(row) == 5) rom_word = GLYPH_W'(8'h10);
          else if (int'(row) == 4)              rom_word = GLYPH_W'(8'h38);
        end else if (int'(glyph_code) == 2) begin
          if (int'(row) == 3 || int'(row) == 5) rom_word = GLYPH_W'(8'h08);
          else if (int'(row) == 4)              rom_word = GLYPH_W'(8'h1C);
        end
      end
    end else begin : g_blank
      logic [AW-1:0] unused_addr;
      assign unused_addr = addr;
      assign rom_word    = '0;
    end
  endgenerate

`ifdef GLYPH_MIRROR_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)       mirror_q <= 1'b0;
    else if (accept) mirror_q <= mirror;
  end
`else
  logic unused_mirror;
  assign unused_mirror = mirror;
  assign mirror_q      = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      rom_q     <= '0;
      shift_reg <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            rom_q <= rom_word;
            state <= FETCH;
          end
        end
        FETCH: begin
          shift_reg <= rom_q;
          cnt       <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          if (pix_ready) begin
            shift_reg <= mirror_q ? (shift_reg >> 1) : (shift_reg << 1);
            cnt       <= cnt + 1'b1;
            if (last) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; pix_ready never reaches them.
  assign ready     = (state == IDLE);
  assign busy      = ~ready;
  assign pix_valid = (state == SHIFT);
  assign pix       = pix_valid & (mirror_q ? shift_reg[0] : shift_reg[GLYPH_W-1]);
  assign pix_last  = pix_valid & last;

endmodule

// File: doc/glyph_row_streamer.md
# glyph_row_streamer

Parametrised glyph ROM with a serialising read engine for the VGA overlay. A requester asks for one row of one glyph. The block performs a registered ROM read, then streams the row one pixel per cycle under a valid/ready handshake, with optional horizontal mirroring. It sits between the note/marker overlay controller and the pixel compositor, replacing direct combinational glyph lookups.

## Interface
Parameters:
- GLYPH_W, 8, pixels per glyph row (bits per ROM word), 2..32
- GLYPH_H, 8, rows per glyph, power of two, 2..32
- NUM_GLYPHS, 4, number of glyph codes, power of two, 2..256
- INIT_FILE, "", $readmemb file, one GLYPH_W-bit word per line, NUM_GLYPHS*GLYPH_H lines; empty selects the built-in table

Ports (one clock; reset is asynchronous and active-high):
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- req  in  1  row request, qualified by ready
- glyph_code  in  $clog2(NUM_GLYPHS)  glyph index
- row  in  $clog2(GLYPH_H)  row within glyph, 0 = top
- mirror  in  1  reverse pixel order (GLYPH_MIRROR_EN only)
- ready  out  1  block idle, request accepted this cycle if req=1
- pix_valid  out  1  pix holds a valid pixel
- pix_ready  in  1  consumer accepts pix this cycle
- pix  out  1  current pixel, 1 = foreground
- pix_last  out  1  qualifies the final pixel of the row
- busy  out  1  inverse of ready

## Operation
- ROM word address = glyph_code*GLYPH_H + row (concatenation). The word MSB is the leftmost pixel.
- Built-in table (used when INIT_FILE is empty and GLYPH_W = 8; otherwise all words are 0):
  - code 0: blank
  - code 1: rows 3/4/5 = 0x10/0x38/0x10 (left-bias dot)
  - code 2: rows 3/4/5 = 0x08/0x1C/0x08 (right-bias dot)
  - code 3: reserved, blank
  - all other rows and codes: 0
- FSM states: IDLE, FETCH, SHIFT.
- IDLE:
  - ready=1.
  - When req=1, latch glyph_code, row and mirror, and drive the ROM address. Next state is FETCH.
- FETCH:
  - One cycle. The registered ROM output loads a GLYPH_W-bit shift register.
  - The pixel counter clears to 0. Next state is SHIFT.
- SHIFT:
  - pix_valid=1.
  - pix = shift_reg[GLYPH_W-1], or shift_reg[0] when mirrored.
  - On pix_valid & pix_ready, shift one position and increment the counter.
  - pix_last=1 when counter = GLYPH_W-1.
  - The transfer with pix_last=1 returns the FSM to IDLE.
- pix_ready low holds pix, pix_last and the counter stable with no timeout.
- req is ignored outside IDLE; there is no queueing.
- Inputs are only sampled at acceptance, so glyph_code, row and mirror may change freely after that cycle.

## Timing
- Reset values: state IDLE, ready=1, busy=0, pix_valid=0, pix=0, pix_last=0, shift register 0, counter 0.
- Request accepted at edge N:
  - FETCH during cycle N+1.
  - First pix_valid in cycle N+2.
  - With pix_ready held high, last pixel in cycle N+1+GLYPH_W; ready=1 in cycle N+2+GLYPH_W.
- Throughput is one row per GLYPH_W+2 cycles. The block does not issue back-to-back rows.
- pix, pix_valid and pix_last are registered or decoded from registered state only, with no combinational path from pix_ready.
- Reset asserted mid-stream: all outputs return to reset values immediately (asynchronously). The partial row is discarded and is not resumed.
- req held high continuously: each request is accepted in the cycle after the previous row completes.

## Configuration
- GLYPH_MIRROR_EN defined:
  - mirror is latched at acceptance.
  - When it is 1, pixels stream LSB-first, giving a right-to-left row.
- GLYPH_MIRROR_EN undefined:
  - The mirror port is present but ignored, and no latch is inferred.
  - Streaming is always MSB-first.

## Test plan
- Reset, then idle: ready=1, pix_valid=0, and all outputs are 0 while Reset=1 and after release.
- req with code 1, row 4, pix_ready=1:
  - pix_valid is first high 2 cycles after acceptance.
  - Stream is 0,0,1,1,1,0,0,0.
  - pix_last is high on the 8th pixel; ready returns 1 the cycle after.
- Code 2, row 3, mirror=1, GLYPH_MIRROR_EN defined: stream 0,0,0,1,0,0,0,0. With the macro undefined: stream 0,0,0,0,1,0,0,0.
- Code 1, row 4, pix_ready low for 3 cycles after the 3rd pixel: pix holds 1 and the counter holds at 2. After release the remaining pixels 1,1,0,0,0 follow with no loss or duplication.
- Reset pulsed during the 5th pixel of a row: outputs clear immediately. A new request afterwards streams a fresh, correct row.
- req held high with codes 1 then 0 presented: two rows, 8 pixels each, separated by exactly 2 non-valid cycles. The second row is all zeros.
